// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-cache, redirect and decode-side
// handshake signals of the fetch front end.
// master = fetch unit side, slave = surrounding core / environment side.
interface fetch_unit_if;
  // Instruction cache
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  // Redirect from execute
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Output stage towards decode
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred_taken;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_pred_taken
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_pred_taken
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Holds the PC, presents it to a combinational instruction cache, registers
// the returned word with its PC in a single output stage and hands it to
// decode over a valid/ready handshake. Redirects from execute flush the
// output stage and reload the PC.
//
// Optional feature: define FETCH_BRANCH_PREDICT_EN to enable static
// prediction (JAL and backward conditional branches predicted taken).
// Without it no decode logic exists, out_pred_taken is constant 0 and the
// PC always advances by 4.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0] pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred_taken;

  logic        fire;
  logic        pred;
  logic [31:0] next_pc;
  logic [31:0] seq_pc;
  logic [31:0] redirect_target;

  // The cache address is the PC register itself: no logic on this path.
  assign bus.imem_addr      = pc;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = out_pc;
  assign bus.out_instr      = out_instr;
  assign bus.out_pred_taken = out_pred_taken;

  // Output stage can take a new entry when empty or being drained.
  assign fire            = ~out_valid | bus.out_ready;
  assign seq_pc          = pc + 32'd4;
  assign redirect_target = bus.redirect_pc & ~32'h3;

`ifdef FETCH_BRANCH_PREDICT_EN
  logic [31:0] pred_target;
  logic [31:0] jal_offset;
  logic [31:0] br_offset;

  assign jal_offset = {{11{bus.imem_instr[31]}}, bus.imem_instr[31],
                       bus.imem_instr[19:12], bus.imem_instr[20],
                       bus.imem_instr[30:21], 1'b0};
  assign br_offset  = {{19{bus.imem_instr[31]}}, bus.imem_instr[31],
                       bus.imem_instr[7], bus.imem_instr[30:25],
                       bus.imem_instr[11:8], 1'b0};

  // Static predictor: JAL always taken, conditional branches taken when backward.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    pred        = 1'b0;
    pred_target = seq_pc;
    if (bus.imem_instr[6:0] == OPC_JAL) begin
      pred        = 1'b1;
      pred_target = pc + jal_offset;
    end else if (bus.imem_instr[6:0] == OPC_BRANCH && bus.imem_instr[31]) begin
      pred        = 1'b1;
      pred_target = pc + br_offset;
    end
  end

  assign next_pc = pred ? pred_target : seq_pc;
`else
  assign pred    = 1'b0;
  assign next_pc = seq_pc;
`endif

  // PC and output stage: reset, then redirect/flush, then fetch, else stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!reset) begin
      pc             <= RESET_PC;
      out_valid      <= 1'b0;
      out_pc         <= 32'h0;
      out_instr      <= 32'h0;
      out_pred_taken <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Wrong-path word on imem_instr is dropped; a concurrent transfer to
      // decode still completes because decode sampled it at this edge.
      pc        <= redirect_target;
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid      <= 1'b1;
      out_pc         <= pc;
      out_instr      <= bus.imem_instr;
      out_pred_taken <= pred;
      pc             <= next_pc;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that drives the combinational instruction cache and delivers instructions to decode. Holds the program counter, presents it to the cache each cycle, registers the returned word with its PC into a single output stage, and hands it downstream over a valid/ready handshake. Accepts redirects from execute for taken branches, jumps and mispredicts. Sits between the instruction cache and the decode stage of the core.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- imem_addr  output  32  fetch address to instruction cache; always equals current pc
- imem_instr  input  32  instruction word returned combinationally for imem_addr
- redirect_valid  input  1  execute requests PC change this cycle
- redirect_pc  input  32  new PC; bits [1:0] ignored (forced to 0)
- out_valid  output  1  out_* holds a valid instruction
- out_ready  input  1  decode accepts out_* this cycle
- out_pc  output  32  address of out_instr
- out_instr  output  32  fetched instruction
- out_pred_taken  output  1  fetch predicted this instruction taken (0 when prediction compiled out)

## Operation
- State: pc (32b), output register {out_valid, out_pc, out_instr, out_pred_taken}.
- imem_addr = pc, combinational from register; no other logic on that path.
- fire = ~out_valid | out_ready (output stage free or being drained).
- Priority per cycle, highest first:
  1. reset low: pc <= RESET_PC; out_valid <= 0; out_pc <= 0; out_instr <= 0; out_pred_taken <= 0.
  2. redirect_valid: pc <= {redirect_pc[31:2], 2'b00}; out_valid <= 0 (flush, regardless of out_ready); imem_instr discarded this cycle.
  3. fire: out_valid <= 1; out_pc <= pc; out_instr <= imem_instr; out_pred_taken <= pred; pc <= next_pc.
  4. else (stall): all state held.
- next_pc = pred ? pred_target : pc + 4. All PC arithmetic 32-bit, modulo 2^32 (pc 0xFFFF_FFFC + 4 wraps to 0x0).
- pred = 0 unless FETCH_BRANCH_PREDICT_EN is defined (see Configuration).
- out_* stable while out_valid & ~out_ready (no redirect).
- Handshake: transfer when out_valid & out_ready at rising edge. out_valid never depends combinationally on out_ready.

## Timing
- imem_addr changes only at clock edges.
- Fetch latency 1 cycle: pc presented in cycle N appears on out_* in N+1.
- Throughput 1 instruction/cycle with out_ready held high.
- Redirect in cycle N: imem_addr = redirect target in N+1; its instruction on out_* in N+2 (out_valid low in N+1).
- Redirect coinciding with out_valid & out_ready: the transfer still completes (decode took it); new entry not loaded.
- First instruction after reset release: out_valid high one cycle after the first cycle with reset high.

## Configuration
- FETCH_BRANCH_PREDICT_EN defined: static prediction on imem_instr.
  - JAL (opcode 7'b1101111): pred = 1, pred_target = pc + sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - B-type (opcode 7'b1100011) with instr[31] = 1 (backward): pred = 1, pred_target = pc + sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - Forward branches, JALR, all else: pred = 0.
  - Execute is responsible for redirecting on mispredict using out_pred_taken.
- Not defined: pred tied 0, out_pred_taken constant 0, next_pc always pc + 4; no decode logic synthesised.

## Test plan
- Reset: hold reset=0 two cycles with random imem_instr -> imem_addr=0, out_valid=0, out_pc=0, out_instr=0; release -> next cycle out_valid=1, out_pc=0.
- Streaming: cache returns 02a00313 @0, 006383b3 @4, 3e800e13 @8, out_ready=1 -> out_pc 0,4,8 on consecutive cycles with matching out_instr.
- Backpressure: out_ready=0 for 3 cycles while out_pc=4 -> out_pc/out_instr held, imem_addr held at 8; out_ready=1 -> out_pc=8 next cycle, no skip or duplicate.
- Redirect: redirect_valid=1, redirect_pc=0x0000_0103 at imem_addr=0xC -> next cycle imem_addr=0x100, out_valid=0; following cycle out_pc=0x100.
- Prediction (macro defined): ffc3cae3 (blt, offset -12) @0xC -> out_pred_taken=1, next imem_addr=0x0; macro undefined -> out_pred_taken=0, next imem_addr=0x10.
- Wrap: RESET_PC=32'hFFFF_FFFC, out_ready=1, non-branch instr -> out_pc FFFF_FFFC then 0x0.
